// File: rtl/deserializer_1to8_pkg.sv
// ---------------------------------------------------------------------------
// deserializer_1to8_pkg
//   Shared constants for the ADC capture-path deserializer.
//   ADC_DES_WIDTH : default number of serial bits per parallel ADC word.
// ---------------------------------------------------------------------------
package deserializer_1to8_pkg;

   localparam int unsigned ADC_DES_WIDTH = 8;

endpackage : deserializer_1to8_pkg

// File: rtl/deserializer_1to8.sv
// ---------------------------------------------------------------------------
// deserializer_1to8
//   Single-lane serial-to-parallel converter for the ADC capture path.
//   One bit of D is sampled on every rising clk edge. Every WIDTH bits,
//   counted from reset release, the assembled word is loaded into Q and
//   q_valid strobes for one cycle. There is no framing or bitslip, and D
//   must already be synchronous to clk.
//
//   Parameters
//     WIDTH     : bits per word (>= 2)
//     MSB_FIRST : 1 -> first received bit lands in Q[WIDTH-1]
//                 0 -> first received bit lands in Q[0]
//
//   Ports
//     clk      in   bit clock, rising-edge sampling
//     rst      in   asynchronous active-high reset
//     D        in   serial data
//     Q        out  last completed word (registered, held until next word)
//     q_valid  out  one-cycle strobe, high while a freshly loaded Q is shown
// ---------------------------------------------------------------------------
module deserializer_1to8
   import deserializer_1to8_pkg::*;
#(
   parameter int unsigned WIDTH     = ADC_DES_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             D,
   output logic [WIDTH-1:0] Q,
   output logic             q_valid
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             q_valid_q, q_valid_d;
   logic             word_done;

   // Shift direction is fixed at elaboration time.
   generate
      if (MSB_FIRST) begin : g_msb_first
         always_comb begin
            sr_d = {sr_q[WIDTH-2:0], D};
         end
      end else begin : g_lsb_first
         always_comb begin
            sr_d = {D, sr_q[WIDTH-1:1]};
         end
      end
   endgenerate

   assign word_done = (cnt_q == CNT_LAST);

   // Q loads the shifted value including the bit sampled on this edge, so
   // the last bit of a word reaches Q with no extra latency.
   always_comb begin
      cnt_d     = cnt_q + CW'(1);
      q_d       = q_q;
      q_valid_d = 1'b0;
      if (word_done) begin
         cnt_d     = '0;
         q_d       = sr_d;
         q_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q      <= '0;
         cnt_q     <= '0;
         q_q       <= '0;
         q_valid_q <= 1'b0;
      end else begin
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
      end
   end

   assign Q       = q_q;
   assign q_valid = q_valid_q;

endmodule : deserializer_1to8

// File: tb/tb_deserializer_1to8.sv
// ---------------------------------------------------------------------------
// tb_deserializer_1to8
//   Directed bench for deserializer_1to8 with WIDTH=8. One instance is
//   MSB-first, a second instance shares the inputs and is LSB-first.
// ---------------------------------------------------------------------------
module tb_deserializer_1to8;

   logic       clk = 1'b0;
   logic       rst;
   logic       D;
   logic [7:0] Q, Q_l;
   logic       qv, qv_l;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   deserializer_1to8 #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .D(D), .Q(Q), .q_valid(qv)
   );

   deserializer_1to8 #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .D(D), .Q(Q_l), .q_valid(qv_l)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: drive one bit, let one rising edge sample it,
   // return at the next falling edge with outputs settled.
   task automatic bit_in(input logic d);
      D = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] e, el;

      rst = 1'b1;
      D   = 1'b0;

      // Reset held with D toggling
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         D = ~D;
         @(posedge clk);
         #1;
         chk("rst_hold_Q", Q, 8'h00);
         chk("rst_hold_qv", {7'd0, qv}, 8'h00);
      end
      @(negedge clk);
      rst = 1'b0;

      // D=0 for edges 1..61, D=1 from edge 62 onward
      for (int i = 1; i <= 80; i++) begin
         bit_in(i >= 62);
         if (i < 64) begin
            e  = 8'h00;
            el = 8'h00;
         end else if (i < 72) begin
            e  = 8'h07;
            el = 8'hE0;
         end else begin
            e  = 8'hFF;
            el = 8'hFF;
         end
         chk("step_Q", Q, e);
         chk("step_Q_lsb", Q_l, el);
         chk("step_qv", {7'd0, qv}, {7'd0, (i % 8) == 0});
      end

      // Three bits into the next word, then async reset between edges
      bit_in(1'b1);
      bit_in(1'b1);
      bit_in(1'b1);
      chk("pre_async_Q", Q, 8'hFF);
      #2;
      rst = 1'b1;
      #1;
      chk("async_clr_Q", Q, 8'h00);
      chk("async_clr_Q_lsb", Q_l, 8'h00);
      chk("async_clr_qv", {7'd0, qv}, 8'h00);
      @(negedge clk);
      chk("rst_edge_Q", Q, 8'h00);
      rst = 1'b0;

      // Pattern 1,0,1,0,0,1,0,1 from the first edge after release
      pat = 8'b1010_0101;
      for (int i = 0; i < 8; i++) begin
         bit_in(pat[7-i]);
         chk("pat_Q", Q, (i == 7) ? 8'hA5 : 8'h00);
         chk("pat_Q_lsb", Q_l, (i == 7) ? 8'hA5 : 8'h00);
         chk("pat_qv", {7'd0, qv}, {7'd0, i == 7});
      end

      // Three bits of a new word, then reset pulse mid-word
      for (int i = 0; i < 3; i++) begin
         bit_in(1'b1);
         chk("hold_Q", Q, 8'hA5);
         chk("hold_qv", {7'd0, qv}, 8'h00);
      end
      rst = 1'b1;
      #1;
      chk("midword_clr_Q", Q, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // Post-reset word 1,1,0,0,1,0,1,0 must appear exactly at edge 8
      pat = 8'b1100_1010;
      for (int i = 0; i < 8; i++) begin
         bit_in(pat[7-i]);
         chk("restart_Q", Q, (i == 7) ? 8'hCA : 8'h00);
         chk("restart_Q_lsb", Q_l, (i == 7) ? 8'h53 : 8'h00);
         chk("restart_qv", {7'd0, qv}, {7'd0, i == 7});
         chk("restart_qv_lsb", {7'd0, qv_l}, {7'd0, i == 7});
      end

      // Bit order: 1,0,0,0,0,0,0,0 -> 0x80 MSB-first, 0x01 LSB-first
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pat = 8'b1000_0000;
      for (int i = 0; i < 8; i++) begin
         bit_in(pat[7-i]);
      end
      chk("order_Q_msb", Q, 8'h80);
      chk("order_Q_lsb", Q_l, 8'h01);
      chk("order_qv", {7'd0, qv}, 8'h01);
      bit_in(1'b0);
      chk("order_qv_drop", {7'd0, qv}, 8'h00);
      chk("order_Q_hold", Q, 8'h80);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_deserializer_1to8

// File: doc/deserializer_1to8.md
# deserializer_1to8

Single-lane serial-to-parallel converter for the ADC capture path. It samples one serial data bit per rising edge of `clk` and assembles consecutive bits into a `WIDTH`-bit word. Each completed word is presented on `Q` and held until the next word completes. It sits directly behind the ADC data input buffer and feeds the parallel sample logic downstream.

## Interface
- `WIDTH`, default 8: bits per output word; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 means the first bit received lands in `Q[WIDTH-1]`; 0 means it lands in `Q[0]`.

Ports:
- `clk`  input  1  bit clock; all sampling on the rising edge.
- `rst`  input  1  asynchronous, active-high reset. This is the only clock and reset of the block.
- `D`  input  1  serial data, sampled on every rising edge of `clk`.
- `Q`  output  WIDTH  last completed parallel word (registered).
- `q_valid`  output  1  one-cycle strobe, high in the cycle after `Q` is updated.

## Operation
- Internal state:
  - shift register `sr[WIDTH-1:0]`;
  - bit counter `cnt`, range 0..WIDTH-1, width `$clog2(WIDTH)`.
- Each rising edge with `rst` low:
  - When `MSB_FIRST`=1: `sr <= {sr[WIDTH-2:0], D}`.
  - When `MSB_FIRST`=0: `sr <= {D, sr[WIDTH-1:1]}`.
  - When `cnt` = WIDTH-1:
    - `Q` loads the word including the current `D` (the same expression as the new `sr`);
    - `q_valid` goes high;
    - `cnt` wraps to 0.
  - Otherwise: `cnt <= cnt+1`, `q_valid` goes low, `Q` holds.
- No frame alignment and no bitslip. Word boundaries are defined solely by the count from reset release.
- `D` is not synchronised inside the block. The upstream logic must deliver it synchronous to `clk`.

## Timing
- Reset values while `rst` is high, applied immediately (asynchronously): `sr`=0, `cnt`=0, `Q`=0, `q_valid`=0.
- Reset asserted mid-word:
  - the partial word is discarded;
  - `Q` clears to 0;
  - counting restarts from bit 0 at the first rising edge after release.
- First word: bits are sampled on edges 1..WIDTH after reset release. `Q` updates on edge WIDTH, and `q_valid` is high for the following cycle.
- Steady state:
  - new word every WIDTH clocks;
  - `Q` is stable for exactly WIDTH cycles;
  - `q_valid` duty is 1/WIDTH.
- Latency: the last bit of a word appears on `Q` at the edge that samples it (0 extra cycles). The first bit of a word appears WIDTH-1 cycles after it is sampled.
- `D` changing mid-word takes effect only for bits sampled after the change. The boundary word contains a mix of old and new bits.

## Structure
- Self-contained: one module, no shared package needed.
- The counter can be a `localparam`-sized always block. A separate sub-module is not warranted.
- If a package exists for the ADC path, `WIDTH` default (8) belongs there as `ADC_DES_WIDTH`.

## Test plan
Use a 10 ns clock, `WIDTH`=8, `MSB_FIRST`=1.
- Reset: hold `rst`=1 with `D` toggling -> `Q`=0x00 and `q_valid`=0 throughout; asserting `rst` mid-word clears `Q` immediately, without waiting for a clock.
- All zeros: `D`=0 for 60 cycles after release -> `Q`=0x00; `q_valid` pulses on cycles 8, 16, 24, ….
- Step input: `D`=0 for 61 cycles, then `D`=1 -> the word ending at edge 64 is 0x07, the next word is 0xFF, and all later words are 0xFF.
- Pattern: send bits 1,0,1,0,0,1,0,1 starting at the first edge after reset -> `Q`=0xA5 on edge 8; with `MSB_FIRST`=0 the same bits give 0xA5 bit-reversed = 0xA5 (use 0x01 pattern 1,0,0,0,0,0,0,0 -> 0x80 vs 0x01 to distinguish).
- Reset mid-word: after 3 bits of a word, pulse `rst` -> the next `Q` update occurs exactly 8 edges after release and contains only post-reset bits.
